// File: rtl/minmax_tracker_pkg.sv
// -----------------------------------------------------------------------------
// minmax_tracker_pkg
//   Shared definitions for the windowed min/max tracker:
//     - state_t : FSM state encoding (ST_EMPTY = 0, ST_ACCUM = 1)
//     - iw_of() : width of an in-window index for a given window length,
//                 max(1, clog2(window))
//   No ports; imported by minmax_tracker and ule_cmp.
// -----------------------------------------------------------------------------
package minmax_tracker_pkg;

    // Tracker state: EMPTY waits for the first sample of a window,
    // ACCUM folds further samples into the running min/max.
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    // Index width for a window of n samples. A window of one sample still
    // needs a 1-bit index port, hence the floor of 1.
    function automatic int unsigned iw_of(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) begin
            w++;
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage : minmax_tracker_pkg

// File: rtl/minmax_tracker_ule_cmp.sv
// -----------------------------------------------------------------------------
// ule_cmp
//   Unsigned less-or-equal comparator: O = (A <= B).
//   Implemented as the carry-out of B + ~A + 1, i.e. B - A produces no borrow
//   exactly when B >= A.
//   Ports:
//     A  in  WIDTH  left operand
//     B  in  WIDTH  right operand
//     O  out 1      1 when A <= B (unsigned, full width)
// -----------------------------------------------------------------------------
module ule_cmp
    import minmax_tracker_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             O
);

    logic [WIDTH-1:0] a_n;
    logic [WIDTH:0]   carry;

    assign a_n      = ~A;
    // The "+1" of the two's-complement subtraction enters as carry-in.
    assign carry[0] = 1'b1;

    // Ripple carry chain: only the carry is needed, so the sum bits are
    // never formed.
    for (genvar k = 0; k < WIDTH; k++) begin : g_carry
        assign carry[k+1] = (B[k] & a_n[k]) | (carry[k] & (B[k] ^ a_n[k]));
    end

    assign O = carry[WIDTH];

endmodule : ule_cmp

// File: rtl/minmax_tracker.sv
// -----------------------------------------------------------------------------
// minmax_tracker
//   Streaming stage that accepts WIDTH-bit unsigned samples over a
//   VALID/READY handshake and tracks the minimum and maximum over fixed,
//   non-overlapping windows of WINDOW samples. At the end of each window it
//   presents MIN, MAX and the index (within the window) of the first
//   occurrence of each, held stable until the downstream accepts them.
//
//   Ports:
//     CLK      in   1      clock, all state on the rising edge
//     RESET    in   1      synchronous, active-low reset
//     I        in   WIDTH  sample
//     IVALID   in   1      sample valid
//     IREADY   out  1      stage accepts sample
//     CLR      in   1      discard the partial window (synchronous)
//     MIN      out  WIDTH  window minimum
//     MAX      out  WIDTH  window maximum
//     MIN_IDX  out  IW     index of first occurrence of MIN in the window
//     MAX_IDX  out  IW     index of first occurrence of MAX in the window
//     OVALID   out  1      result valid
//     OREADY   in   1      downstream accepts result
//   IW = max(1, clog2(WINDOW)).
// -----------------------------------------------------------------------------
module minmax_tracker
    import minmax_tracker_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned WINDOW = 8
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [WIDTH-1:0]            I,
    input  logic                        IVALID,
    output logic                        IREADY,
    input  logic                        CLR,
    output logic [WIDTH-1:0]            MIN,
    output logic [WIDTH-1:0]            MAX,
    output logic [iw_of(WINDOW)-1:0]    MIN_IDX,
    output logic [iw_of(WINDOW)-1:0]    MAX_IDX,
    output logic                        OVALID,
    input  logic                        OREADY
);

    localparam int unsigned  IW       = iw_of(WINDOW);
    localparam logic [IW-1:0] LAST_IDX = IW'(WINDOW - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q,       state_d;
    logic [IW-1:0]      cnt_q,         cnt_d;
    logic [WIDTH-1:0]   run_min_q,     run_min_d;
    logic [WIDTH-1:0]   run_max_q,     run_max_d;
    logic [IW-1:0]      run_min_idx_q, run_min_idx_d;
    logic [IW-1:0]      run_max_idx_q, run_max_idx_d;

    logic [WIDTH-1:0]   min_q,         min_d;
    logic [WIDTH-1:0]   max_q,         max_d;
    logic [IW-1:0]      min_idx_q,     min_idx_d;
    logic [IW-1:0]      max_idx_q,     max_idx_d;
    logic               ovalid_q,      ovalid_d;

    // ------------------------------------------------------------------
    // Comparators
    // ------------------------------------------------------------------
    // min_keep: run_min <= I, the running minimum survives (ties keep the
    //           earlier index).
    // max_keep: I <= run_max, the running maximum survives.
    logic min_keep;
    logic max_keep;

    ule_cmp #(.WIDTH(WIDTH)) u_min_cmp (
        .A (run_min_q),
        .B (I),
        .O (min_keep)
    );

    ule_cmp #(.WIDTH(WIDTH)) u_max_cmp (
        .A (I),
        .B (run_max_q),
        .O (max_keep)
    );

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic iready;
    logic accept;
    logic drain;

    // A pending result blocks input unless it is being drained this same
    // cycle, which lets a full-rate stream run with OREADY held high.
    assign iready = RESET & (~ovalid_q | OREADY);
    assign accept = IVALID & iready;
    assign drain  = ovalid_q & OREADY;

    // ------------------------------------------------------------------
    // Running-value update for the sample being accepted
    // ------------------------------------------------------------------
    logic               fresh;
    logic [IW-1:0]      idx;
    logic               last;
    logic [WIDTH-1:0]   upd_min;
    logic [WIDTH-1:0]   upd_max;
    logic [IW-1:0]      upd_min_idx;
    logic [IW-1:0]      upd_max_idx;

    // CLR restarts the window, so a sample accepted alongside it is treated
    // exactly like the first sample after EMPTY: index 0, seeds min and max.
    assign fresh = CLR | (state_q == ST_EMPTY);
    assign idx   = fresh ? '0 : cnt_q;
    assign last  = (idx == LAST_IDX);

    always_comb begin
        upd_min     = run_min_q;
        upd_max     = run_max_q;
        upd_min_idx = run_min_idx_q;
        upd_max_idx = run_max_idx_q;
        if (fresh) begin
            upd_min     = I;
            upd_max     = I;
            upd_min_idx = '0;
            upd_max_idx = '0;
        end else begin
            if (!min_keep) begin
                upd_min     = I;
                upd_min_idx = idx;
            end
            if (!max_keep) begin
                upd_max     = I;
                upd_max_idx = idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        run_min_d     = run_min_q;
        run_max_d     = run_max_q;
        run_min_idx_d = run_min_idx_q;
        run_max_idx_d = run_max_idx_q;
        min_d         = min_q;
        max_d         = max_q;
        min_idx_d     = min_idx_q;
        max_idx_d     = max_idx_q;
        ovalid_d      = ovalid_q;

        // Discard the partial window; a pending result is left alone.
        if (CLR) begin
            state_d       = ST_EMPTY;
            cnt_d         = '0;
            run_min_d     = '0;
            run_max_d     = '0;
            run_min_idx_d = '0;
            run_max_idx_d = '0;
        end

        if (drain) begin
            ovalid_d = 1'b0;
        end

        if (accept) begin
            if (last) begin
                // Window complete: publish and restart. Overrides a same-cycle
                // drain so OVALID stays high with the new result.
                state_d       = ST_EMPTY;
                cnt_d         = '0;
                run_min_d     = '0;
                run_max_d     = '0;
                run_min_idx_d = '0;
                run_max_idx_d = '0;
                min_d         = upd_min;
                max_d         = upd_max;
                min_idx_d     = upd_min_idx;
                max_idx_d     = upd_max_idx;
                ovalid_d      = 1'b1;
            end else begin
                state_d       = ST_ACCUM;
                cnt_d         = idx + IW'(1);
                run_min_d     = upd_min;
                run_max_d     = upd_max;
                run_min_idx_d = upd_min_idx;
                run_max_idx_d = upd_max_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers (FSM, counter, running values, output holding registers)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q       <= ST_EMPTY;
            cnt_q         <= '0;
            run_min_q     <= '0;
            run_max_q     <= '0;
            run_min_idx_q <= '0;
            run_max_idx_q <= '0;
            min_q         <= '0;
            max_q         <= '0;
            min_idx_q     <= '0;
            max_idx_q     <= '0;
            ovalid_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            run_min_q     <= run_min_d;
            run_max_q     <= run_max_d;
            run_min_idx_q <= run_min_idx_d;
            run_max_idx_q <= run_max_idx_d;
            min_q         <= min_d;
            max_q         <= max_d;
            min_idx_q     <= min_idx_d;
            max_idx_q     <= max_idx_d;
            ovalid_q      <= ovalid_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign IREADY  = iready;
    assign MIN     = min_q;
    assign MAX     = max_q;
    assign MIN_IDX = min_idx_q;
    assign MAX_IDX = max_idx_q;
    assign OVALID  = ovalid_q;

endmodule : minmax_tracker

// File: tb/tb_minmax_tracker.sv
// -----------------------------------------------------------------------------
// tb_minmax_tracker
//   Two trackers share one input stream: WINDOW=4 and WINDOW=1 (WIDTH=4).
//   A reference model stores each window's samples in an array and derives
//   min/max/first-index directly from them when the window fills.
// -----------------------------------------------------------------------------
module tb_minmax_tracker;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned WIN0  = 4;
    localparam int unsigned WIN1  = 1;

    logic             CLK    = 1'b0;
    logic             RESET  = 1'b0;
    logic [WIDTH-1:0] I      = '0;
    logic             IVALID = 1'b0;
    logic             CLR    = 1'b0;
    logic             OREADY = 1'b0;

    logic             ird0, ov0, ird1, ov1;
    logic [WIDTH-1:0] min0, max0, min1, max1;
    logic [1:0]       mini0, maxi0;
    logic [0:0]       mini1, maxi1;

    always #5 CLK = ~CLK;

    minmax_tracker #(.WIDTH(WIDTH), .WINDOW(WIN0)) u_dut0 (
        .CLK     (CLK),
        .RESET   (RESET),
        .I       (I),
        .IVALID  (IVALID),
        .IREADY  (ird0),
        .CLR     (CLR),
        .MIN     (min0),
        .MAX     (max0),
        .MIN_IDX (mini0),
        .MAX_IDX (maxi0),
        .OVALID  (ov0),
        .OREADY  (OREADY)
    );

    minmax_tracker #(.WIDTH(WIDTH), .WINDOW(WIN1)) u_dut1 (
        .CLK     (CLK),
        .RESET   (RESET),
        .I       (I),
        .IVALID  (IVALID),
        .IREADY  (ird1),
        .CLR     (CLR),
        .MIN     (min1),
        .MAX     (max1),
        .MIN_IDX (mini1),
        .MAX_IDX (maxi1),
        .OVALID  (ov1),
        .OREADY  (OREADY)
    );

    // ------------------------------------------------------------------
    // Reference model state, one slot per tracker
    // ------------------------------------------------------------------
    int unsigned m_win  [2] = '{WIN0, WIN1};
    int unsigned m_samp [2][WIN0];
    int unsigned m_n    [2] = '{0, 0};
    bit          m_ov   [2] = '{1'b0, 1'b0};
    int unsigned m_min  [2] = '{0, 0};
    int unsigned m_max  [2] = '{0, 0};
    int unsigned m_mini [2] = '{0, 0};
    int unsigned m_maxi [2] = '{0, 0};

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_update(input int k, input bit rst_n, input bit acc,
                                input bit clr, input bit ordy, input int unsigned d);
        bit drained;
        if (!rst_n) begin
            m_n[k] = 0; m_ov[k] = 0;
            m_min[k] = 0; m_max[k] = 0; m_mini[k] = 0; m_maxi[k] = 0;
            return;
        end
        drained = m_ov[k] && ordy;
        if (drained) m_ov[k] = 0;
        if (clr) m_n[k] = 0;
        if (acc) begin
            m_samp[k][m_n[k]] = d;
            m_n[k]++;
            if (m_n[k] == m_win[k]) begin
                m_min[k] = m_samp[k][0]; m_mini[k] = 0;
                m_max[k] = m_samp[k][0]; m_maxi[k] = 0;
                for (int j = 1; j < int'(m_win[k]); j++) begin
                    if (m_samp[k][j] < m_min[k]) begin m_min[k] = m_samp[k][j]; m_mini[k] = j; end
                    if (m_samp[k][j] > m_max[k]) begin m_max[k] = m_samp[k][j]; m_maxi[k] = j; end
                end
                m_ov[k] = 1;
                m_n[k]  = 0;
            end
        end
    endtask

    // One clock cycle: drive inputs, check IREADY mid-cycle, advance the
    // model across the edge, then check all registered outputs.
    task automatic step(input bit rst_n, input bit v, input bit c, input bit r, input int unsigned d);
        bit exp_rdy [2];
        RESET = rst_n; IVALID = v; CLR = c; OREADY = r; I = WIDTH'(d);
        @(negedge CLK);
        for (int k = 0; k < 2; k++) exp_rdy[k] = rst_n && (!m_ov[k] || r);
        check("iready0", ird0, exp_rdy[0]);
        check("iready1", ird1, exp_rdy[1]);
        @(posedge CLK);
        #1;
        for (int k = 0; k < 2; k++) model_update(k, rst_n, v && exp_rdy[k], c, r, d);
        check("ovalid0", ov0,   m_ov[0]);
        check("min0",    min0,  m_min[0]);
        check("max0",    max0,  m_max[0]);
        check("minidx0", mini0, m_mini[0]);
        check("maxidx0", maxi0, m_maxi[0]);
        check("ovalid1", ov1,   m_ov[1]);
        check("min1",    min1,  m_min[1]);
        check("max1",    max1,  m_max[1]);
        check("minidx1", mini1, m_mini[1]);
        check("maxidx1", maxi1, m_maxi[1]);
    endtask

    task automatic feed(input int unsigned d);
        step(1, 1, 0, 1, d);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1, 0, 0, 1, 0);
    endtask

    initial begin
        @(posedge CLK);
        #1;
        // Reset state
        for (int j = 0; j < 3; j++) step(0, 1, 0, 1, 4'h9);

        // 5,2,9,2: result the cycle after the 4th accept
        feed(5); feed(2); feed(9);
        check("t1_ovalid_early", ov0, 1'b0);
        feed(2);
        check("t1_ovalid", ov0,   1'b1);
        check("t1_min",    min0,  4'h2);
        check("t1_minidx", mini0, 2'd1);
        check("t1_max",    max0,  4'h9);
        check("t1_maxidx", maxi0, 2'd2);
        idle(2);

        // Extremes with ties: first index kept
        feed(4'hF); feed(0); feed(4'hF); feed(0);
        check("t2_min",    min0,  4'h0);
        check("t2_minidx", mini0, 2'd1);
        check("t2_max",    max0,  4'hF);
        check("t2_maxidx", maxi0, 2'd0);
        idle(2);

        // Backpressure: result held, input stalled, then same-cycle drain/accept
        for (int j = 0; j < 4; j++) step(1, 1, 0, 0, 3);
        for (int j = 0; j < 3; j++) step(1, 1, 0, 0, 4'hE);
        check("t3_held_min", min0, 4'h3);
        feed(8); feed(6); feed(7); feed(9);
        check("t3_min",    min0,  4'h6);
        check("t3_minidx", mini0, 2'd1);
        check("t3_max",    max0,  4'h9);
        check("t3_maxidx", maxi0, 2'd3);
        idle(2);

        // CLR with a concurrent accept starts a new window at index 0
        feed(7); feed(1);
        step(1, 1, 1, 1, 4);
        feed(6); feed(5); feed(8);
        check("t4_min",    min0,  4'h4);
        check("t4_minidx", mini0, 2'd0);
        check("t4_max",    max0,  4'h8);
        check("t4_maxidx", maxi0, 2'd3);
        idle(2);

        // Reset mid-window
        feed(0); feed(4'hF);
        step(0, 1, 0, 1, 2);
        step(0, 0, 0, 1, 0);
        feed(1); feed(2); feed(3); feed(4);
        check("t5_min",    min0,  4'h1);
        check("t5_minidx", mini0, 2'd0);
        check("t5_max",    max0,  4'h4);
        check("t5_maxidx", maxi0, 2'd3);
        idle(2);

        // WINDOW=1: back-to-back single-sample results
        feed(4'hA);
        check("t6_a_ov",  ov1,  1'b1);
        check("t6_a_min", min1, 4'hA);
        feed(4'hB);
        check("t6_b_ov",  ov1,  1'b1);
        check("t6_b_max", max1, 4'hB);
        idle(2);

        // Randomized traffic
        for (int j = 0; j < 800; j++) begin
            bit          rr, vv, cc, oo;
            int unsigned dd;
            rr = ($urandom_range(0, 99) != 0);
            vv = ($urandom_range(0, 3) != 0);
            cc = ($urandom_range(0, 29) == 0);
            oo = ($urandom_range(0, 2) != 0);
            dd = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 15);
            step(rr, vv, cc, oo, dd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_minmax_tracker
